// File: rtl/vending_machine_multi.sv
// Multi-item vending controller: saturating coin credit, per-item pricing,
// and greedy 25/10/5 change returned one coin per cycle.
module vending_machine_multi #(
   parameter int                            N_ITEMS    = 4,
   parameter int                            CREDIT_W   = 7,
   parameter int                            MAX_CREDIT = 100,
   parameter logic [N_ITEMS*CREDIT_W-1:0]   PRICES     = {7'd100, 7'd65, 7'd45, 7'd30}
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         coin_5,
   input  logic                         coin_10,
   input  logic                         coin_25,
   input  logic                         coin_return,
   input  logic                         item_req,
   input  logic [$clog2(N_ITEMS)-1:0]   item_sel,
   output logic                         dispense_item,
   output logic [$clog2(N_ITEMS)-1:0]   dispense_id,
   output logic                         return_5,
   output logic                         return_10,
   output logic                         return_25,
   output logic                         coin_reject,
   output logic                         insufficient,
   output logic                         busy,
   output logic [CREDIT_W-1:0]          amount_display
);

   localparam int                  SEL_W = $clog2(N_ITEMS);
   localparam logic [CREDIT_W-1:0] V5    = CREDIT_W'(5);
   localparam logic [CREDIT_W-1:0] V10   = CREDIT_W'(10);
   localparam logic [CREDIT_W-1:0] V25   = CREDIT_W'(25);
   localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_CREDIT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DISPENSE,
      S_CHANGE
   } state_t;

   state_t               state_q;
   logic [CREDIT_W-1:0]  credit_q;
   logic                 dispense_item_q;
   logic [SEL_W-1:0]     dispense_id_q;
   logic                 return_5_q;
   logic                 return_10_q;
   logic                 return_25_q;
   logic                 coin_reject_q;
   logic                 insufficient_q;
   logic                 busy_q;

   logic [2:0]           coin_vec;
   logic                 any_coin;
   logic                 single_coin;
   logic [CREDIT_W-1:0]  coin_val;
   logic [CREDIT_W:0]    credit_sum;
   logic                 sum_fits;
   logic [CREDIT_W-1:0]  sel_price;
   logic                 sel_valid;
   logic [CREDIT_W-1:0]  chg_val;
   logic [2:0]           chg_sel;   // {25, 10, 5}

   assign coin_vec    = {coin_25, coin_10, coin_5};
   assign any_coin    = |coin_vec;
   assign single_coin = $onehot(coin_vec);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      coin_val = '0;
      if (coin_25)      coin_val = V25;
      else if (coin_10) coin_val = V10;
      else if (coin_5)  coin_val = V5;
   end

   assign credit_sum = {1'b0, credit_q} + {1'b0, coin_val};
   assign sum_fits   = credit_sum <= {1'b0, MAX_C};

   // An out-of-range selection matches no entry and is refused as insufficient.
   always_comb begin
      sel_price = '0;
      sel_valid = 1'b0;
      for (int i = 0; i < N_ITEMS; i++) begin
         if (int'(item_sel) == i) begin
            sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
            sel_valid = 1'b1;
         end
      end
   end

   always_comb begin
      chg_val = '0;
      chg_sel = 3'b000;
      if (credit_q >= V25) begin
         chg_val = V25;
         chg_sel = 3'b100;
      end else if (credit_q >= V10) begin
         chg_val = V10;
         chg_sel = 3'b010;
      end else if (credit_q >= V5) begin
         chg_val = V5;
         chg_sel = 3'b001;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         credit_q        <= '0;
         dispense_item_q <= 1'b0;
         dispense_id_q   <= '0;
         return_5_q      <= 1'b0;
         return_10_q     <= 1'b0;
         return_25_q     <= 1'b0;
         coin_reject_q   <= 1'b0;
         insufficient_q  <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         dispense_item_q <= 1'b0;
         return_5_q      <= 1'b0;
         return_10_q     <= 1'b0;
         return_25_q     <= 1'b0;
         coin_reject_q   <= 1'b0;
         insufficient_q  <= 1'b0;
         busy_q          <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (coin_return) begin
                  coin_reject_q <= any_coin;
                  if (credit_q != '0) begin
                     state_q     <= S_CHANGE;
                     credit_q    <= credit_q - chg_val;
                     return_25_q <= chg_sel[2];
                     return_10_q <= chg_sel[1];
                     return_5_q  <= chg_sel[0];
                     busy_q      <= 1'b1;
                  end
               end else if (item_req) begin
                  coin_reject_q <= any_coin;
                  if (sel_valid && credit_q >= sel_price) begin
                     state_q         <= S_DISPENSE;
                     credit_q        <= credit_q - sel_price;
                     dispense_item_q <= 1'b1;
                     dispense_id_q   <= item_sel;
                     busy_q          <= 1'b1;
                  end else begin
                     insufficient_q <= 1'b1;
                  end
               end else if (any_coin) begin
                  if (single_coin && sum_fits) credit_q <= credit_sum[CREDIT_W-1:0];
                  else                         coin_reject_q <= 1'b1;
               end
            end

            S_DISPENSE, S_CHANGE: begin
               // Coins arriving mid-transaction go straight back to the tray.
               coin_reject_q <= any_coin;
               if (credit_q != '0) begin
                  state_q     <= S_CHANGE;
                  credit_q    <= credit_q - chg_val;
                  return_25_q <= chg_sel[2];
                  return_10_q <= chg_sel[1];
                  return_5_q  <= chg_sel[0];
                  busy_q      <= 1'b1;
               end else begin
                  state_q <= S_IDLE;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign dispense_item  = dispense_item_q;
   assign dispense_id    = dispense_id_q;
   assign return_5       = return_5_q;
   assign return_10      = return_10_q;
   assign return_25      = return_25_q;
   assign coin_reject    = coin_reject_q;
   assign insufficient   = insufficient_q;
   assign busy           = busy_q;
   assign amount_display = credit_q;

   a_credit_range : assert property (@(posedge clk) disable iff (!rst_n)
      credit_q <= MAX_C);
   a_credit_mult5 : assert property (@(posedge clk) disable iff (!rst_n)
      (32'(credit_q) % 32'd5) == 32'd0);
   a_one_return   : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0({return_25_q, return_10_q, return_5_q}));
   a_no_overlap   : assert property (@(posedge clk) disable iff (!rst_n)
      !(dispense_item_q && (return_25_q || return_10_q || return_5_q)));

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench for vending_machine_multi: hand-computed expected outputs
// checked on the falling edge after each driven cycle.
module tb_vending_machine_multi;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       coin_5, coin_10, coin_25, coin_return, item_req;
   logic [1:0] item_sel;
   logic       dispense_item;
   logic [1:0] dispense_id;
   logic       return_5, return_10, return_25;
   logic       coin_reject, insufficient, busy;
   logic [6:0] amount_display;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   vending_machine_multi dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .coin_5         (coin_5),
      .coin_10        (coin_10),
      .coin_25        (coin_25),
      .coin_return    (coin_return),
      .item_req       (item_req),
      .item_sel       (item_sel),
      .dispense_item  (dispense_item),
      .dispense_id    (dispense_id),
      .return_5       (return_5),
      .return_10      (return_10),
      .return_25      (return_25),
      .coin_reject    (coin_reject),
      .insufficient   (insufficient),
      .busy           (busy),
      .amount_display (amount_display)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Packed view {disp, id, r25, r10, r5, reject, insuff, busy, amount}; id only counts with the pulse.
   function automatic logic [15:0] pk(input bit d, input logic [1:0] id, input bit r25, input bit r10,
                                      input bit r5, input bit rej, input bit ins, input bit bsy,
                                      input logic [6:0] amt);
      return {d, id, r25, r10, r5, rej, ins, bsy, amt};
   endfunction

   function automatic logic [15:0] obs();
      return pk(dispense_item, dispense_item ? dispense_id : 2'd0, return_25, return_10, return_5,
                coin_reject, insufficient, busy, amount_display);
   endfunction

   task automatic step(input bit c5, input bit c10, input bit c25, input bit ret, input bit req,
                       input logic [1:0] sel);
      coin_5      = c5;
      coin_10     = c10;
      coin_25     = c25;
      coin_return = ret;
      item_req    = req;
      item_sel    = sel;
      @(negedge clk);
      coin_5      = 1'b0;
      coin_10     = 1'b0;
      coin_25     = 1'b0;
      coin_return = 1'b0;
      item_req    = 1'b0;
      item_sel    = 2'd0;
   endtask

   task automatic idle();   step(0, 0, 0, 0, 0, 2'd0); endtask
   task automatic c5();     step(1, 0, 0, 0, 0, 2'd0); endtask
   task automatic c10();    step(0, 1, 0, 0, 0, 2'd0); endtask
   task automatic c25();    step(0, 0, 1, 0, 0, 2'd0); endtask
   task automatic ret();    step(0, 0, 0, 1, 0, 2'd0); endtask
   task automatic req(input logic [1:0] sel); step(0, 0, 0, 0, 1, sel); endtask

   initial begin
      rst_n       = 1'b0;
      coin_5      = 1'b0;
      coin_10     = 1'b0;
      coin_25     = 1'b0;
      coin_return = 1'b0;
      item_req    = 1'b0;
      item_sel    = 2'd0;
      repeat (2) @(negedge clk);
      check("reset", obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      rst_n = 1'b1;
      idle();
      check("idle after reset", obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Exact payment, no change
      c5();      check("t1 c5",      obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 5));
      c10();     check("t1 c10",     obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 15));
      c10();     check("t1 c10b",    obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 25));
      c5();      check("t1 c5b",     obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 30));
      req(2'd0); check("t1 disp",    obs(), pk(1, 0, 0, 0, 0, 0, 0, 1, 0));
      idle();    check("t1 after",   obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      idle();    check("t1 idle",    obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Two-coin change of 10s
      c25();     check("t2 c25",     obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 25));
      c25();     check("t2 c25b",    obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 50));
      req(2'd0); check("t2 disp",    obs(), pk(1, 0, 0, 0, 0, 0, 0, 1, 20));
      idle();    check("t2 chg1",    obs(), pk(0, 0, 0, 1, 0, 0, 0, 1, 10));
      idle();    check("t2 chg2",    obs(), pk(0, 0, 0, 1, 0, 0, 0, 1, 0));
      idle();    check("t2 done",    obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Credit ceiling and most expensive item
      c25();     check("t3 25",      obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 25));
      c25();     check("t3 50",      obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 50));
      c25();     check("t3 75",      obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 75));
      c25();     check("t3 100",     obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 100));
      c5();      check("t3 overflow", obs(), pk(0, 0, 0, 0, 0, 1, 0, 0, 100));
      idle();    check("t3 rej clr", obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 100));
      req(2'd3); check("t3 disp3",   obs(), pk(1, 3, 0, 0, 0, 0, 0, 1, 0));
      idle();    check("t3 done",    obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Insufficient credit, then refund
      c10();     check("t4 c10",     obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 10));
      req(2'd1); check("t4 insuff",  obs(), pk(0, 0, 0, 0, 0, 0, 1, 0, 10));
      idle();    check("t4 ins clr", obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 10));
      ret();     check("t4 refund",  obs(), pk(0, 0, 0, 1, 0, 0, 0, 1, 0));
      idle();    check("t4 done",    obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Simultaneous coins, coin during change, mixed change
      step(1, 1, 0, 0, 0, 2'd0);
      check("t5 dual coin", obs(), pk(0, 0, 0, 0, 0, 1, 0, 0, 0));
      c25();     check("t5 25",      obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 25));
      c25();     check("t5 50",      obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 50));
      c10();     check("t5 60",      obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 60));
      req(2'd0); check("t5 disp",    obs(), pk(1, 0, 0, 0, 0, 0, 0, 1, 30));
      idle();    check("t5 chg25",   obs(), pk(0, 0, 1, 0, 0, 0, 0, 1, 5));
      c25();     check("t5 chg5 rej", obs(), pk(0, 0, 0, 0, 1, 1, 0, 1, 0));
      idle();    check("t5 done",    obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Reset in the middle of change
      c25();     check("t6 25",      obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 25));
      c10();     check("t6 35",      obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 35));
      c5();      check("t6 40",      obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 40));
      ret();     check("t6 chg25",   obs(), pk(0, 0, 1, 0, 0, 0, 0, 1, 15));
      rst_n = 1'b0;
      #1;
      check("t6 async rst", obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      check("t6 held rst", obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      rst_n = 1'b1;
      idle();    check("t6 idle",    obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      c5();      check("t6 alive",   obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 5));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
